// File: rtl/polyphase_pkg.sv
// Shared types, default widths and tap-count helper for the polyphase MAC scheduler.
// Optional watchdog in the scheduler top is enabled by defining MAC_SCHED_WDOG_EN.
package polyphase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } sched_state_t;

  localparam int N_DEF   = 31;
  localparam int M_DEF   = 2;
  localparam int COEF_AW = $clog2(N_DEF);
  localparam int BR_W    = $clog2(M_DEF);
  localparam int TAP_W   = $clog2((N_DEF + M_DEF - 1) / M_DEF + 1);

  // Branch b owns taps b, b+M, b+2M, ... below n.
  function automatic int taps_for_branch(input int n, input int m, input int b);
    return (n - b + m - 1) / m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i, cyclically.
module rr_arbiter
  import polyphase_pkg::*;
#(
  parameter int M    = 2,
  parameter int BR_W = $clog2(M)
) (
  input  logic [M-1:0]    req_i,
  input  logic [BR_W-1:0] ptr_i,
  output logic [M-1:0]    gnt_oh_o,
  output logic [BR_W-1:0] gnt_bin_o,
  output logic            any_o
);

  always_comb begin : p_pick
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_bin_o = '0;
    for (int i = 1; i <= M; i++) begin
      idx = (int'(ptr_i) + i) % M;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_bin_o      = BR_W'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/polyphase_mac_scheduler.sv
// Shares one MAC among M polyphase branches: round-robin grant, per-tap issue, result hand-off.
// Define MAC_SCHED_WDOG_EN to add the DRAIN watchdog and its sticky wdog_err output.
module polyphase_mac_scheduler
  import polyphase_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int N            = 31,
  parameter int M            = 2,
  parameter int ACC_WIDTH    = 37,
  parameter int MAC_LATENCY  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M-1:0]             req,
  output logic [M-1:0]             grant,
  output logic [M-1:0]             done,
  output logic                     mac_en,
  output logic                     mac_clear,
  output logic                     mac_last,
  output logic [$clog2(N)-1:0]     coef_addr,
  output logic [$clog2(M)-1:0]     branch_idx,
  input  logic                     mac_result_valid,
  input  logic [ACC_WIDTH-1:0]     mac_result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [ACC_WIDTH-1:0]     result_data,
  output logic [$clog2(M)-1:0]     result_branch,
  output logic [1:0]               dbg_state
`ifdef MAC_SCHED_WDOG_EN
  ,
  output logic                     wdog_err
`endif
);

  localparam int CA_W = $clog2(N);
  localparam int BW   = $clog2(M);
  localparam int TW   = $clog2((N + M - 1) / M + 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ISSUE  = ST_ISSUE;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_OUTPUT = ST_OUTPUT;

  if (ACC_WIDTH < 2 * SAMPLE_WIDTH || MAC_LATENCY < 1 || M < 2 || N < M) begin : g_bad_cfg
    $error("polyphase_mac_scheduler: inconsistent parameters");
  end
  if (N == N_DEF && M == M_DEF && (CA_W != COEF_AW || BW != BR_W || TW != TAP_W)) begin : g_bad_pkg
    $error("polyphase_mac_scheduler: package widths disagree with defaults");
  end

  logic [1:0]           state_q, state_d;
  logic [M-1:0]         grant_q, grant_d;
  logic [M-1:0]         done_q, done_d;
  logic [BW-1:0]        br_q, br_d;
  logic [BW-1:0]        rr_q, rr_d;
  logic [TW-1:0]        tap_q, tap_d;
  logic [CA_W-1:0]      addr_q, addr_d;
  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]        last_tap;

  logic [M-1:0]         arb_oh;
  logic [BW-1:0]        arb_bin;
  logic                 arb_any;

`ifdef MAC_SCHED_WDOG_EN
  localparam int WD_LIM = 4 * MAC_LATENCY;
  localparam int WD_W   = $clog2(WD_LIM + 1);
  logic [WD_W-1:0] wcnt_q, wcnt_d;
  logic            wdog_q, wdog_d;
`endif

  rr_arbiter #(.M(M), .BR_W(BW)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_bin_o (arb_bin),
    .any_o     (arb_any)
  );

  assign last_tap = TW'(taps_for_branch(N, M, int'(br_q)) - 1);

  // Result port: a beat transfers on any cycle where result_valid && result_ready;
  // while result_valid is high and ready is low, data and branch stay frozen.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    br_d    = br_q;
    rr_d    = rr_q;
    tap_d   = tap_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MAC_SCHED_WDOG_EN
    wcnt_d  = wcnt_q;
    wdog_d  = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant_d = arb_oh;
          br_d    = arb_bin;
          tap_d   = '0;
          addr_d  = CA_W'(arb_bin);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tap_d  = tap_q + TW'(1);
        addr_d = addr_q + CA_W'(M);
`ifdef MAC_SCHED_WDOG_EN
        wcnt_d = '0;
`endif
        if (tap_q == last_tap) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (mac_result_valid) begin
          data_d  = mac_result;
          state_d = S_OUTPUT;
        end
`ifdef MAC_SCHED_WDOG_EN
        // A silent MAC still releases the branch, with a zero result.
        else if (wcnt_q == WD_W'(WD_LIM - 1)) begin
          wdog_d  = 1'b1;
          data_d  = '0;
          state_d = S_OUTPUT;
        end else begin
          wcnt_d = wcnt_q + WD_W'(1);
        end
`endif
      end
      S_OUTPUT: begin
        if (result_ready) begin
          done_d  = grant_q;
          grant_d = '0;
          rr_d    = br_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      br_q    <= '0;
      rr_q    <= BW'(M - 1);
      tap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MAC_SCHED_WDOG_EN
      wcnt_q  <= '0;
      wdog_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      br_q    <= br_d;
      rr_q    <= rr_d;
      tap_q   <= tap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MAC_SCHED_WDOG_EN
      wcnt_q  <= wcnt_d;
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign mac_en        = (state_q == S_ISSUE);
  assign mac_clear     = mac_en && (tap_q == '0);
  assign mac_last      = mac_en && (tap_q == last_tap);
  assign coef_addr     = mac_en ? addr_q : '0;
  assign branch_idx    = (state_q != S_IDLE) ? br_q : '0;
  assign result_valid  = (state_q == S_OUTPUT);
  assign result_data   = result_valid ? data_q : '0;
  assign result_branch = result_valid ? br_q : '0;
  assign dbg_state     = state_q;
`ifdef MAC_SCHED_WDOG_EN
  assign wdog_err      = wdog_q;
`endif

endmodule

// File: tb/tb_polyphase_mac_scheduler.sv
// Randomized bench for polyphase_mac_scheduler with a MAC emulator and a spec-level reference model.
module tb_polyphase_mac_scheduler;

  localparam int SW   = 16;
  localparam int N    = 31;
  localparam int M    = 2;
  localparam int AW   = 37;
  localparam int LAT  = 3;
  localparam int CA_W = $clog2(N);
  localparam int BW   = $clog2(M);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [M-1:0]    req;
  logic [M-1:0]    grant;
  logic [M-1:0]    done;
  logic            mac_en, mac_clear, mac_last;
  logic [CA_W-1:0] coef_addr;
  logic [BW-1:0]   branch_idx;
  logic            mac_result_valid;
  logic [AW-1:0]   mac_result;
  logic            result_valid;
  logic            result_ready;
  logic [AW-1:0]   result_data;
  logic [BW-1:0]   result_branch;
  logic [1:0]      dbg_state;
`ifdef MAC_SCHED_WDOG_EN
  logic            wdog_err;
`endif

  polyphase_mac_scheduler #(
    .SAMPLE_WIDTH(SW), .N(N), .M(M), .ACC_WIDTH(AW), .MAC_LATENCY(LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .grant            (grant),
    .done             (done),
    .mac_en           (mac_en),
    .mac_clear        (mac_clear),
    .mac_last         (mac_last),
    .coef_addr        (coef_addr),
    .branch_idx       (branch_idx),
    .mac_result_valid (mac_result_valid),
    .mac_result       (mac_result),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_data      (result_data),
    .result_branch    (result_branch),
    .dbg_state        (dbg_state)
`ifdef MAC_SCHED_WDOG_EN
    ,
    .wdog_err         (wdog_err)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [SW-1:0] coef [N];
  logic [SW-1:0] samp [N];
  logic [AW-1:0] exp_q[$];
  int            expb_q[$];
  int            iss_q[$];
  int            obs_q[$];
  int            model_rr, owner;
  bit            idle_prev, hs_prev, spur_en, mac_silent;
  logic [M-1:0]  req_v, req_prev, grant_seen;
  int            rv_cycles, stall_cfg, mac_pend;
  logic [AW-1:0] mac_acc, mac_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] oh(input int b);
    return M'(1) << b;
  endfunction

  function automatic int ref_winner(input logic [M-1:0] r, input int last);
    for (int k = 1; k <= M; k++) begin
      if (r[(last + k) % M]) return (last + k) % M;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] ref_sum(input int b);
    logic [AW-1:0] s;
    s = '0;
    for (int a = b; a < N; a += M) s += AW'(coef[a]) * AW'(samp[a]);
    return s;
  endfunction

  task automatic model_init();
    model_rr   = M - 1;
    owner      = 0;
    idle_prev  = 1'b1;
    hs_prev    = 1'b0;
    req_v      = '0;
    req_prev   = '0;
    grant_seen = '0;
    rv_cycles  = 0;
    mac_pend   = 0;
    mac_acc    = '0;
    mac_out    = '0;
    iss_q.delete();
    exp_q.delete();
    expb_q.delete();
  endtask

  task automatic check_zero();
    check("rst_grant", grant, '0);
    check("rst_done", done, '0);
    check("rst_mac_en", mac_en, '0);
    check("rst_mac_clear", mac_clear, '0);
    check("rst_mac_last", mac_last, '0);
    check("rst_coef_addr", coef_addr, '0);
    check("rst_branch_idx", branch_idx, '0);
    check("rst_result_valid", result_valid, '0);
    check("rst_result_data", result_data, '0);
    check("rst_result_branch", result_branch, '0);
    check("rst_state", dbg_state, '0);
`ifdef MAC_SCHED_WDOG_EN
    check("rst_wdog_err", wdog_err, '0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b0;
    req = '0;
    result_ready = 1'b0;
    mac_result_valid = 1'b0;
    mac_result = '0;
    #1 check_zero();
    repeat (3) @(negedge clk);
    check_zero();
    model_init();
    reset = 1'b1;
  endtask

  // One cycle: observe outputs at the falling edge, check against the model, drive next inputs.
  task automatic tick();
    int            win, a;
    logic          ready_next, hs_now, mv, idle_now;
    logic [AW-1:0] md;
    @(negedge clk);
    hs_now   = 1'b0;
    idle_now = 1'b0;

    if (hs_prev) begin
      check("done_pulse", done, oh(owner));
      check("grant_release", grant, '0);
      model_rr = owner;
      req_v    = req_v & ~oh(owner);
      idle_now = 1'b1;
    end else begin
      check("done_quiet", done, '0);
      if (idle_prev) begin
        win = ref_winner(req_prev, model_rr);
        if (win >= 0) begin
          check("grant_new", grant, oh(win));
          owner = win;
          for (int t = win; t < N; t += M) iss_q.push_back(t);
          exp_q.push_back(mac_silent ? '0 : ref_sum(win));
          expb_q.push_back(win);
        end else begin
          check("grant_idle", grant, '0);
          idle_now = 1'b1;
        end
      end else begin
        check("grant_hold", grant, oh(owner));
      end
    end
    if (grant != '0 && grant_seen == '0) begin
      for (int b = 0; b < M; b++) if (grant[b]) obs_q.push_back(b);
    end
    grant_seen = grant;

    if (iss_q.size() > 0) begin
      a = iss_q.pop_front();
      check("mac_en", mac_en, 1'b1);
      check("coef_addr", coef_addr, a);
      check("mac_clear", mac_clear, a == owner);
      check("mac_last", mac_last, (a + M) >= N);
      check("branch_idx", branch_idx, owner);
    end else begin
      check("mac_en_quiet", mac_en, 1'b0);
    end

    // MAC emulator: accumulates whatever the DUT issues.
    mv = 1'b0;
    md = AW'({$urandom(), $urandom()});
    if (mac_pend > 0) begin
      mac_pend--;
      if (mac_pend == 0 && !mac_silent) begin
        mv = 1'b1;
        md = mac_out;
      end
    end
    if (mac_en) begin
      if (mac_clear) mac_acc = '0;
      if (int'(coef_addr) < N) mac_acc += AW'(coef[coef_addr]) * AW'(samp[coef_addr]);
      if (mac_last) begin
        mac_out  = mac_acc;
        mac_pend = LAT;
      end
    end

    ready_next = 1'($urandom_range(0, 1));
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        check("result_unexpected", result_valid, 1'b0);
        ready_next = 1'b1;
      end else begin
        check("result_data", result_data, exp_q[0]);
        check("result_branch", result_branch, expb_q[0]);
        rv_cycles++;
        ready_next = (rv_cycles > stall_cfg);
        if (ready_next) begin
          hs_now = 1'b1;
          void'(exp_q.pop_front());
          void'(expb_q.pop_front());
          rv_cycles = 0;
        end
      end
    end else if (rv_cycles > 0) begin
      check("valid_hold", result_valid, 1'b1);
      rv_cycles = 0;
    end
    if (!mv && spur_en && result_valid && !hs_now && $urandom_range(0, 1) == 1) mv = 1'b1;

    result_ready     = ready_next;
    mac_result_valid = mv;
    mac_result       = md;
    req              = req_v;
    req_prev         = req_v;
    idle_prev        = idle_now;
    hs_prev          = hs_now;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(req_v == '0 && exp_q.size() == 0 && idle_prev && !hs_prev) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check("job_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      coef[i] = SW'($urandom());
      samp[i] = SW'($urandom());
    end
    spur_en = 1'b0;
    mac_silent = 1'b0;
    stall_cfg = 0;
    model_init();
    #2;
    apply_reset();
    repeat (5) tick();

    req_v = 2'b01;
    wait_idle(200);
    req_v = 2'b10;
    wait_idle(200);

    apply_reset();
    obs_q.delete();
    req_v = 2'b11;
    wait_idle(300);
    req_v = 2'b11;
    wait_idle(300);
    check("order_len", obs_q.size(), 4);
    if (obs_q.size() >= 3) begin
      check("order_0", obs_q[0], 0);
      check("order_1", obs_q[1], 1);
      check("order_2", obs_q[2], 0);
    end

    stall_cfg = 5;
    req_v = 2'b01;
    wait_idle(200);
    stall_cfg = 0;

    req_v = 2'b10;
    guard = 0;
    while (idle_prev && guard < 20) begin tick(); guard++; end
    req_v = '0;
    wait_idle(200);

    spur_en = 1'b1;
    for (int j = 0; j < 500; j++) begin
      if ($urandom_range(0, 3) == 0) req_v = req_v | oh($urandom_range(0, M - 1));
      if (rv_cycles == 0) stall_cfg = $urandom_range(0, 3);
      tick();
    end
    wait_idle(400);
    spur_en = 1'b0;
    stall_cfg = 0;

    req_v = 2'b01;
    guard = 0;
    while (!(iss_q.size() > 0 && iss_q.size() < 10) && guard < 50) begin tick(); guard++; end
    check("mid_issue_mac_en", mac_en, 1'b1);
    apply_reset();
    repeat (10) tick();

`ifdef MAC_SCHED_WDOG_EN
    check("wdog_clear", wdog_err, 1'b0);
    mac_silent = 1'b1;
    req_v = 2'b01;
    wait_idle(200);
    mac_silent = 1'b0;
    check("wdog_set", wdog_err, 1'b1);
    req_v = 2'b10;
    wait_idle(200);
    check("wdog_sticky", wdog_err, 1'b1);
    apply_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
